// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_tx, uart_rx and uart_tx_queue.
//   BYTE_W       : width of one UART data byte.
//   CLKS_PER_BIT : default bit period in i_clk cycles (115200 baud at 50 MHz).
//   tx_state_t   : state encoding of the uart_tx_queue send sequencer.
package uart_pkg;

  localparam int BYTE_W       = 8;
  localparam int CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a sticky overflow flag.
//   clk, rst  : clock and synchronous active-high reset (control state only)
//   wr_en     : write strobe; ignored (and overflow set) when full
//   wr_data   : data written on an accepted write
//   rd_en     : pop strobe; ignored when empty
//   rd_data   : entry at the read pointer (committed data only, no bypass)
//   count     : occupancy 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
//   overflow  : sticky, set when a write is dropped; cleared by rst only
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_acc  = wr_en && !full;
  assign rd_acc  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      // Fullness is judged before any same-cycle pop frees a slot.
      if (wr_en && full) overflow <= 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and send sequencer feeding uart_tx. Bytes written by any
// producer are buffered and replayed one frame at a time, waiting for the
// transmitter's done pulse plus GAP_CYCLES idle cycles between frames.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_wr_dv      : one-cycle write strobe
//   i_wr_byte    : byte written when i_wr_dv=1
//   o_tx_dv      : one-cycle start pulse to uart_tx
//   o_tx_byte    : byte to uart_tx, held from o_tx_dv until i_tx_done
//   i_tx_active  : uart_tx frame in progress
//   i_tx_done    : uart_tx frame complete (one-cycle pulse)
//   o_count      : FIFO occupancy 0..DEPTH
//   o_full       : o_count == DEPTH
//   o_empty      : o_count == 0
//   o_overflow   : sticky, a write was dropped
//   o_busy       : sequencer not idle
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int GAP_CYCLES = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_dv,
  input  logic [BYTE_W-1:0] i_wr_byte,
  output logic              o_tx_dv,
  output logic [BYTE_W-1:0] o_tx_byte,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic [AW:0]       o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  output logic              o_busy
);

  localparam int          GW       = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [GW-1:0]     gap_cnt;
  logic              pop;
  logic [BYTE_W-1:0] fifo_byte;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_en    (i_wr_dv),
    .wr_data  (i_wr_byte),
    .rd_en    (pop),
    .rd_data  (fifo_byte),
    .count    (o_count),
    .full     (o_full),
    .empty    (o_empty),
    .overflow (o_overflow)
  );

  // A done pulse only matters in ST_WAIT; a stale one after a reset
  // mid-frame lands in ST_IDLE and is ignored.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!o_empty && !i_tx_active) begin
          pop       = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      o_tx_byte <= '0;
    end else begin
      state <= state_nxt;
      if (pop) o_tx_byte <= fifo_byte;
      if (state == ST_GAP) gap_cnt <= gap_cnt + GAP_ONE;
      else                 gap_cnt <= '0;
    end
  end

  assign o_tx_dv = (state == ST_SEND);
  assign o_busy  = (state != ST_IDLE);

endmodule
